// File: rtl/nano_v_registers.sv
// rtl/nano_v_registers.sv - bit-serial RV32E register file, x1..x15 rotating LSB-first
// x0 has no storage; a stall flop loaded from pause gates every rotation and write.
module nano_v_registers (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pause,
  input  logic       wr_en,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  input  logic [3:0] rd,
  output logic       data_rs1,
  output logic       data_rs2,
  input  logic       data_rd
);

  logic [31:0] regs_q [1:15];
  logic [31:0] regs_d [1:15];
  logic        stall_q;
  logic [15:0] lsb;

  // rstn is an active-high asynchronous reset despite its name.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      stall_q <= 1'b1;
      for (int i = 1; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      stall_q <= pause;
      for (int i = 1; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 1; i < 16; i++) begin
      regs_d[i] = regs_q[i];
      if (!stall_q) begin
        regs_d[i] = {regs_q[i][0], regs_q[i][31:1]};
        if (wr_en && (rd == 4'(i))) begin
          regs_d[i][31] = data_rd;
        end
      end
    end
  end

  // Current LSB of every register, with slot 0 tied low for x0.
  always_comb begin
    lsb[0] = 1'b0;
    for (int i = 1; i < 16; i++) begin
      lsb[i] = regs_q[i][0];
    end
  end

  assign data_rs1 = lsb[rs1];
  assign data_rs2 = lsb[rs2];

endmodule

// File: tb/tb_nano_v_registers.sv
// tb/tb_nano_v_registers.sv - directed self-checking bench for nano_v_registers
module tb_nano_v_registers;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       pause = 1'b0;
  logic       wr_en = 1'b0;
  logic       data_rd = 1'b0;
  logic [3:0] rs1 = 4'd0;
  logic [3:0] rs2 = 4'd0;
  logic [3:0] rd = 4'd0;
  logic       data_rs1;
  logic       data_rs2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nano_v_registers dut (
    .clk      (clk),
    .rstn     (rstn),
    .pause    (pause),
    .wr_en    (wr_en),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .data_rs1 (data_rs1),
    .data_rs2 (data_rs2),
    .data_rd  (data_rd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One 32-cycle word: optional serial write, both read ports captured LSB first.
  task automatic xfer(input logic we, input logic [3:0] wd, input logic [31:0] wv,
                      input logic [3:0] r1, input logic [3:0] r2,
                      output logic [31:0] g1, output logic [31:0] g2);
    for (int k = 0; k < 32; k++) begin
      wr_en   = we;
      rd      = wd;
      data_rd = wv[k];
      rs1     = r1;
      rs2     = r2;
      #1;
      g1[k] = data_rs1;
      g2[k] = data_rs2;
      tick();
    end
    wr_en = 1'b0;
  endtask

  // The first edge after release must be stalled, so the write of x1 attempted there is lost.
  task automatic do_reset;
    rstn  = 1'b1;
    pause = 1'b0;
    wr_en = 1'b0;
    tick();
    rstn    = 1'b0;
    wr_en   = 1'b1;
    rd      = 4'd1;
    data_rd = 1'b1;
    tick();
    wr_en   = 1'b0;
    data_rd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] g1;
    logic [31:0] g2;
    logic [31:0] pv;
    logic [4:0]  frz;

    pv  = 32'hA5A5F00F;
    frz = '0;

    @(negedge clk);
    rstn = 1'b1;
    rs1  = 4'd5;
    rs2  = 4'd9;
    #1;
    check("reset_rs1", {31'b0, data_rs1}, 32'h0);
    check("reset_rs2", {31'b0, data_rs2}, 32'h0);
    @(negedge clk);
    do_reset();
    xfer(1'b0, 4'd0, 32'h0, 4'd1, 4'd1, g1, g2);
    check("first_edge_stalled", g1, 32'h0);

    xfer(1'b1, 4'd5, 32'hDEADBEEF, 4'd0, 4'd0, g1, g2);
    xfer(1'b0, 4'd0, 32'h0, 4'd5, 4'd0, g1, g2);
    check("x5_readback", g1, 32'hDEADBEEF);

    xfer(1'b1, 4'd0, 32'hFFFFFFFF, 4'd0, 4'd0, g1, g2);
    xfer(1'b0, 4'd0, 32'h0, 4'd0, 4'd0, g1, g2);
    check("x0_rs1", g1, 32'h0);
    check("x0_rs2", g2, 32'h0);

    xfer(1'b1, 4'd3, 32'h12345678, 4'd0, 4'd0, g1, g2);
    xfer(1'b1, 4'd15, 32'h87654321, 4'd0, 4'd0, g1, g2);
    xfer(1'b0, 4'd0, 32'h0, 4'd3, 4'd15, g1, g2);
    check("dual_rs1_x3", g1, 32'h12345678);
    check("dual_rs2_x15", g2, 32'h87654321);
    xfer(1'b0, 4'd0, 32'h0, 4'd3, 4'd3, g1, g2);
    check("same_rs1_x3", g1, 32'h12345678);
    check("same_rs2_x3", g2, 32'h12345678);

    // Pause asserted while bit 10 is presented: edge for bit 10 is still active,
    // the next five edges freeze, so port 2 holds x3 bit 11 (0) throughout.
    for (int k = 0; k < 32; k++) begin
      wr_en   = 1'b1;
      rd      = 4'd11;
      rs1     = 4'd0;
      rs2     = 4'd3;
      data_rd = pv[k];
      pause   = (k == 10);
      #1;
      g2[k] = data_rs2;
      tick();
      if (k == 10) begin
        for (int j = 0; j < 5; j++) begin
          pause   = (j < 4);
          data_rd = 1'($urandom);
          #1;
          frz[j] = data_rs2;
          tick();
        end
      end
    end
    pause = 1'b0;
    wr_en = 1'b0;
    check("pause_freeze", {27'b0, frz}, 32'h0);
    check("pause_x3_stream", g2, 32'h12345678);
    xfer(1'b0, 4'd0, 32'h0, 4'd11, 4'd3, g1, g2);
    check("pause_x11_readback", g1, 32'hA5A5F00F);
    check("pause_x3_after", g2, 32'h12345678);

    xfer(1'b1, 4'd7, 32'h0000FFFF, 4'd0, 4'd0, g1, g2);
    xfer(1'b1, 4'd7, 32'hFFFF0000, 4'd7, 4'd0, g1, g2);
    check("rdw_old_value", g1, 32'h0000FFFF);
    xfer(1'b0, 4'd0, 32'h0, 4'd7, 4'd0, g1, g2);
    check("rdw_new_value", g1, 32'hFFFF0000);

    xfer(1'b1, 4'd9, 32'hCAFEBABE, 4'd0, 4'd0, g1, g2);
    rs1 = 4'd9;
    #1;
    check("x9_bit0", {31'b0, data_rs1}, 32'h0);
    tick();
    #1;
    check("x9_bit1", {31'b0, data_rs1}, 32'h1);
    #2;
    rstn = 1'b1;
    #1;
    check("x9_async_clear", {31'b0, data_rs1}, 32'h0);
    @(negedge clk);
    do_reset();
    xfer(1'b0, 4'd0, 32'h0, 4'd9, 4'd3, g1, g2);
    check("x9_after_reset", g1, 32'h0);
    check("x3_after_reset", g2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
